// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: the NOP encoding, the fetch-stage
// FSM states and the default reset PC.
package mips_pkg;

  // All-zero word (sll $0,$0,0) used as the pipeline bubble instruction.
  localparam logic [31:0] NOP = 32'h0000_0000;

  // Default program counter after reset.
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // FETCH: request outstanding for PCF.
  // DRAIN: request for an abandoned PC outstanding, redirect waiting.
  // HELD : word captured while fetch was stalled, no request outstanding.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    HELD  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: hold beats flush, flush beats load, and anything
// else leaves a bubble behind.
module if_id_reg
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_hold,
  input  logic        i_flush,
  input  logic        i_load,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc_plus4,
  output logic [31:0] o_cmd,
  output logic [31:0] o_pc_plus4,
  output logic        o_valid
);

  logic [31:0] r_cmd;
  logic [31:0] r_pc_plus4;
  logic        r_valid;

  // Register update in priority order: reset, hold, flush, load, bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cmd      <= NOP;
      r_pc_plus4 <= 32'h0;
      r_valid    <= 1'b0;
    end else if (i_hold) begin
      r_cmd      <= r_cmd;
      r_pc_plus4 <= r_pc_plus4;
      r_valid    <= r_valid;
    end else if (i_load && !i_flush) begin
      r_cmd      <= i_instr;
      r_pc_plus4 <= i_pc_plus4;
      r_valid    <= 1'b1;
    end else begin
      r_cmd      <= NOP;
      r_pc_plus4 <= 32'h0;
      r_valid    <= 1'b0;
    end
  end

  assign o_cmd      = r_cmd;
  assign o_pc_plus4 = r_pc_plus4;
  assign o_valid    = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns PCF, drives the request/ready instruction
// memory port, absorbs memory latency, stalls and redirects, and feeds the
// IF/ID register.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        PCSrcD,
  input  logic [31:0] PCBranchD,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemReady,
  input  logic [31:0] IMemData,
  output logic [31:0] cmd,
  output logic [31:0] PCPlusFourD,
  output logic        ValidD
);

  fetch_state_t r_state;
  fetch_state_t w_state_next;
  logic [31:0]  r_pc;
  logic [31:0]  w_pc_next;
  logic [31:0]  r_hold;
  logic [31:0]  w_hold_next;
  logic [31:0]  r_redir_pc;
  logic [31:0]  w_redir_pc_next;
  logic [31:0]  w_pc_plus4;
  logic [31:0]  w_deliver_word;
  logic         w_deliver;
  logic         w_accept;
  logic         w_redir;

  // The request depends only on state; reset forces it low so that no beat
  // is started while the pipeline is being cleared.
  assign IMemReq    = ~reset & (r_state != HELD);
  assign IMemAddr   = r_pc;
  assign w_accept   = IMemReq & IMemReady;
  assign w_redir    = PCSrcD & ~StallD;
  assign w_pc_plus4 = r_pc + 32'd4;

  // State, PC and side registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= FETCH;
      r_pc       <= RESET_PC;
      r_hold     <= NOP;
      r_redir_pc <= 32'h0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_hold     <= w_hold_next;
      r_redir_pc <= w_redir_pc_next;
    end
  end

  // Next-state, next-PC and delivery decision.
  always_comb begin
    w_state_next    = r_state;
    w_pc_next       = r_pc;
    w_hold_next     = r_hold;
    w_redir_pc_next = r_redir_pc;
    w_deliver       = 1'b0;
    w_deliver_word  = IMemData;
    case (r_state)
      FETCH: begin
        if (w_accept) begin
          if (w_redir) begin
            w_pc_next = PCBranchD;          // wrong-path word dropped
          end else if (StallF) begin
            w_hold_next  = IMemData;        // park it until decode frees up
            w_state_next = HELD;
          end else begin
            w_deliver = 1'b1;
            w_pc_next = w_pc_plus4;
          end
        end else if (w_redir) begin
          // The beat cannot be retracted, so remember where to go next.
          w_redir_pc_next = PCBranchD;
          w_state_next    = DRAIN;
        end
      end
      DRAIN: begin
        if (w_redir) begin
          w_redir_pc_next = PCBranchD;      // latest redirect wins
        end
        if (w_accept) begin
          w_pc_next    = w_redir ? PCBranchD : r_redir_pc;
          w_state_next = FETCH;
        end
      end
      HELD: begin
        w_deliver_word = r_hold;
        if (w_redir) begin
          w_pc_next    = PCBranchD;
          w_state_next = FETCH;
        end else if (!StallF) begin
          w_deliver    = 1'b1;
          w_pc_next    = w_pc_plus4;
          w_state_next = FETCH;
        end
      end
      default: begin
        w_state_next = FETCH;
      end
    endcase
  end

  if_id_reg u_if_id_reg (
    .clk        (clk),
    .reset      (reset),
    .i_hold     (StallD),
    .i_flush    (w_redir),
    .i_load     (w_deliver),
    .i_instr    (w_deliver_word),
    .i_pc_plus4 (w_pc_plus4),
    .o_cmd      (cmd),
    .o_pc_plus4 (PCPlusFourD),
    .o_valid    (ValidD)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a directed vector table from reset, hand-written
// reset-in-HELD / reset-in-DRAIN sequences, and a randomized run checked
// against a program-order model of the instruction stream.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        StallF = 1'b0;
  logic        StallD = 1'b0;
  logic        PCSrcD = 1'b0;
  logic [31:0] PCBranchD = 32'h0;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemReady = 1'b0;
  logic [31:0] IMemData;
  logic [31:0] cmd;
  logic [31:0] PCPlusFourD;
  logic        ValidD;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0)) dut (
    .clk        (clk),
    .reset      (reset),
    .StallF     (StallF),
    .StallD     (StallD),
    .PCSrcD     (PCSrcD),
    .PCBranchD  (PCBranchD),
    .IMemReq    (IMemReq),
    .IMemAddr   (IMemAddr),
    .IMemReady  (IMemReady),
    .IMemData   (IMemData),
    .cmd        (cmd),
    .PCPlusFourD(PCPlusFourD),
    .ValidD     (ValidD)
  );

  // Instruction memory contents: ADDI-style words, never zero in the
  // address range used here, so a real instruction differs from a bubble.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h2008_0000 ^ a;
  endfunction

  assign IMemData = mem_word(IMemAddr);

  always @(posedge clk) begin
    if (!reset) assert (StallF == StallD) else $error("StallF/StallD differ");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else pass_cnt++;
  endtask

  typedef struct {
    logic        stall;
    logic        pcsrc;
    logic [31:0] br;
    logic        rdy;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_cmd;
    logic [31:0] exp_pc4;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic ps, input logic [31:0] br,
                              input logic rd, input logic req, input logic [31:0] addr,
                              input logic v, input logic [31:0] c, input logic [31:0] p4);
    vec_t r;
    r.stall = st; r.pcsrc = ps; r.br = br; r.rdy = rd;
    r.exp_req = req; r.exp_addr = addr;
    r.exp_valid = v; r.exp_cmd = c; r.exp_pc4 = p4;
    return r;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    StallF = 0; StallD = 0; PCSrcD = 0; PCBranchD = 0; IMemReady = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {31'h0, IMemReq}, 32'h0);
    chk("rst_valid", {31'h0, ValidD}, 32'h0);
    chk("rst_cmd", cmd, 32'h0);
    chk("rst_pc4", PCPlusFourD, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_first_req", {31'h0, IMemReq}, 32'h1);
    chk("rst_first_addr", IMemAddr, 32'h0);
  endtask

  vec_t tbl[15];

  initial begin
    logic [31:0] exp_pc;
    logic        e_valid;
    logic [31:0] e_cmd, e_pc4;
    logic        pend;
    logic [31:0] pend_addr;
    logic        redir;
    int          deliveries;

    // Zero-wait stream, redirect bubble, stall across an accept (HELD),
    // stalled redirect then released redirect into DRAIN.
    tbl[0]  = mk(0,0,0,      1, 1,32'h00, 1,mem_word(32'h00),32'h04);
    tbl[1]  = mk(0,0,0,      1, 1,32'h04, 1,mem_word(32'h04),32'h08);
    tbl[2]  = mk(0,0,0,      1, 1,32'h08, 1,mem_word(32'h08),32'h0C);
    tbl[3]  = mk(0,0,0,      1, 1,32'h0C, 1,mem_word(32'h0C),32'h10);
    tbl[4]  = mk(0,1,32'h40, 1, 1,32'h10, 0,32'h0,32'h0);
    tbl[5]  = mk(0,0,0,      1, 1,32'h40, 1,mem_word(32'h40),32'h44);
    tbl[6]  = mk(1,0,0,      1, 1,32'h44, 1,mem_word(32'h40),32'h44);
    tbl[7]  = mk(1,0,0,      1, 0,32'h44, 1,mem_word(32'h40),32'h44);
    tbl[8]  = mk(0,0,0,      1, 0,32'h44, 1,mem_word(32'h44),32'h48);
    tbl[9]  = mk(0,0,0,      1, 1,32'h48, 1,mem_word(32'h48),32'h4C);
    tbl[10] = mk(1,1,32'h100,0, 1,32'h4C, 1,mem_word(32'h48),32'h4C);
    tbl[11] = mk(0,1,32'h100,0, 1,32'h4C, 0,32'h0,32'h0);
    tbl[12] = mk(0,0,0,      0, 1,32'h4C, 0,32'h0,32'h0);
    tbl[13] = mk(0,0,0,      1, 1,32'h4C, 0,32'h0,32'h0);
    tbl[14] = mk(0,0,0,      1, 1,32'h100,1,mem_word(32'h100),32'h104);

    do_reset();

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      StallF = tbl[i].stall; StallD = tbl[i].stall;
      PCSrcD = tbl[i].pcsrc; PCBranchD = tbl[i].br; IMemReady = tbl[i].rdy;
      #1;
      chk($sformatf("vec%0d_req", i), {31'h0, IMemReq}, {31'h0, tbl[i].exp_req});
      chk($sformatf("vec%0d_addr", i), IMemAddr, tbl[i].exp_addr);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_valid", i), {31'h0, ValidD}, {31'h0, tbl[i].exp_valid});
      chk($sformatf("vec%0d_cmd", i), cmd, tbl[i].exp_cmd);
      chk($sformatf("vec%0d_pc4", i), PCPlusFourD, tbl[i].exp_pc4);
      $display("vec %0d: addr=%h cmd=%h pc4=%h valid=%b", i, tbl[i].exp_addr, cmd, PCPlusFourD, ValidD);
    end

    // Reset while HELD: IF/ID holds a real instruction until reset hits.
    @(negedge clk);
    StallF = 1; StallD = 1; PCSrcD = 0; IMemReady = 1;
    @(posedge clk);
    #1;
    chk("held_req", {31'h0, IMemReq}, 32'h0);
    chk("held_cmd", cmd, mem_word(32'h100));
    #2 reset = 1'b1;
    #1;
    chk("held_rst_valid", {31'h0, ValidD}, 32'h0);
    chk("held_rst_cmd", cmd, 32'h0);
    chk("held_rst_req", {31'h0, IMemReq}, 32'h0);
    chk("held_rst_addr", IMemAddr, 32'h0);
    @(negedge clk);
    reset = 1'b0; StallF = 0; StallD = 0; IMemReady = 0;
    #1;
    chk("held_rel_req", {31'h0, IMemReq}, 32'h1);
    $display("seq reset-in-HELD done");

    // Reset while DRAIN (abandoned fetch at 4, redirect to 200 pending).
    @(negedge clk);
    IMemReady = 1;
    @(negedge clk);
    IMemReady = 0; PCSrcD = 1; PCBranchD = 32'h200;
    @(negedge clk);
    PCSrcD = 0;
    #1;
    chk("drain_req", {31'h0, IMemReq}, 32'h1);
    chk("drain_addr", IMemAddr, 32'h4);
    #2 reset = 1'b1;
    #1;
    chk("drain_rst_req", {31'h0, IMemReq}, 32'h0);
    chk("drain_rst_addr", IMemAddr, 32'h0);
    chk("drain_rst_pc4", PCPlusFourD, 32'h0);
    @(negedge clk);
    reset = 1'b0; IMemReady = 1;
    #1;
    chk("drain_rel_addr", IMemAddr, 32'h0);
    @(posedge clk);
    #1;
    chk("drain_rel_cmd", cmd, mem_word(32'h0));
    chk("drain_rel_pc4", PCPlusFourD, 32'h4);
    $display("seq reset-in-DRAIN done");

    // Randomized run against the program-order model: every delivered
    // instruction must be the next one in program order, where a taken
    // redirect restarts the order at its target.
    do_reset();
    exp_pc = 32'h0;
    e_valid = 0; e_cmd = 0; e_pc4 = 0;
    pend = 0; pend_addr = 0;
    deliveries = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      StallF = ($urandom_range(0, 99) < 20);
      StallD = StallF;
      PCSrcD = ($urandom_range(0, 99) < 12);
      PCBranchD = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      IMemReady = ($urandom_range(0, 99) < 60);
      #1;
      if (pend) begin
        chk("rnd_req_held", {31'h0, IMemReq}, 32'h1);
        chk("rnd_addr_held", IMemAddr, pend_addr);
      end
      pend = IMemReq & ~IMemReady;
      pend_addr = IMemAddr;
      redir = PCSrcD & ~StallD;
      @(posedge clk);
      #1;
      if (StallD) begin
        // IF/ID keeps whatever it had.
      end else if (redir) begin
        exp_pc = PCBranchD;
        e_valid = 0; e_cmd = 0; e_pc4 = 0;
      end else if (ValidD) begin
        e_valid = 1; e_cmd = mem_word(exp_pc); e_pc4 = exp_pc + 32'd4;
        exp_pc = exp_pc + 32'd4;
        deliveries++;
      end else begin
        e_valid = 0; e_cmd = 0; e_pc4 = 0;
      end
      chk("rnd_ifid", {ValidD, cmd, PCPlusFourD}, {e_valid, e_cmd, e_pc4});
      $display("rnd %0d: stall=%b redir=%b rdy=%b valid=%b cmd=%h pc4=%h", cyc, StallD, redir, IMemReady, ValidD, cmd, PCPlusFourD);
    end
    total_cnt++;
    if (deliveries < 200) $display("FAIL rnd_progress: got %0d deliveries expected at least 200", deliveries);
    else pass_cnt++;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Global time limit so the bench always ends.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
